hls_bridge_mem: RTL



---
 rtl/hls_bridge_pkg.sv | 22 ++
 rtl/hls_bridge_ram.sv | 32 +++
 rtl/hls_bridge_mem.sv | 81 ++++++++
 3 files changed

// File: rtl/hls_bridge_pkg.sv
// Shared constants and types for the HLS bridge memory target.
package hls_bridge_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MASK_WIDTH = DEF_DATA_WIDTH / 8;

  // Bit positions of each command FIFO in cmd_empty_n
  localparam int CMD_ADDRESS  = 0;
  localparam int CMD_DATA     = 1;
  localparam int CMD_MASK     = 2;
  localparam int CMD_WRITE    = 3;
  localparam int CMD_UNCACHED = 4;
  localparam int CMD_SIZE     = 5;
  localparam int CMD_LAST     = 6;
  localparam int CMD_FIFOS    = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/hls_bridge_ram.sv
// Single-port synchronous scratchpad, byte write enables, 1-cycle registered read.
module hls_bridge_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int MASK_W    = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [MASK_W-1:0]     be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // One independent byte-wide array per lane so each lane infers its own BRAM column
  for (genvar i = 0; i < MASK_W; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we && be[i]) mem[addr] <= wdata[8*i +: 8];
        q <= mem[addr];
      end
    end

    assign rdata[8*i +: 8] = q;
  end

endmodule

// File: rtl/hls_bridge_mem.sv
// Pops the bridge's seven command FIFOs, services them against a local scratchpad,
// and pushes read responses into the two response FIFOs.
module hls_bridge_mem
  import hls_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 1024,
  localparam int MASK_W    = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_address_dout,
  input  logic [DATA_WIDTH-1:0] cmd_data_dout,
  input  logic [MASK_W-1:0]     cmd_mask_dout,
  input  logic                  cmd_write_dout,
  input  logic                  cmd_uncached_dout,
  input  logic [2:0]            cmd_size_dout,
  input  logic                  cmd_last_dout,
  input  logic [CMD_FIFOS-1:0]  cmd_empty_n,
  output logic                  cmd_read,
  output logic [DATA_WIDTH-1:0] rsp_data_din,
  output logic                  rsp_last_din,
  input  logic [1:0]            rsp_full_n,
  output logic                  rsp_write,
  output logic [15:0]           oob_count
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  state_e                state;
  logic                  in_range;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  unused_ok;

  assign unused_ok = cmd_uncached_dout ^ (^cmd_size_dout);

  assign in_range  = cmd_address_dout < DEPTH_A;
  assign cmd_read  = rst_n && (state == IDLE) && (&cmd_empty_n);
  assign rsp_write = rst_n && (state == RESP) && (&rsp_full_n);

  // RAM output register holds the read word through RESP; out-of-range reads show 0
  assign rsp_data_din = (state == RESP && rd_ok) ? ram_q : '0;

  hls_bridge_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (cmd_read),
    .we    (cmd_write_dout && in_range),
    .be    (cmd_mask_dout),
    .addr  (cmd_address_dout[IDX_W-1:0]),
    .wdata (cmd_data_dout),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_ok        <= 1'b0;
      rsp_last_din <= 1'b0;
      oob_count    <= '0;
    end else begin
      if (cmd_read && !in_range && oob_count != 16'hFFFF)
        oob_count <= oob_count + 16'd1;
      case (state)
        IDLE: if (cmd_read && !cmd_write_dout) begin
          state        <= RESP;
          rd_ok        <= in_range;
          rsp_last_din <= cmd_last_dout;
        end
        RESP: if (rsp_write) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
